timer_device: RTL and testbench
===============================

Name: timer_device

Overview:
Memory-mapped programmable timer. It is the bus responder and interrupt source that the mips core services through its interrupt/exception path.
- The CPU writes and reads three 32-bit registers over a simple bridge interface (addr/we/wdata/rdata).
- The timer counts down from a preset value and raises irq to the CP0 interrupt input.
- Sits on the bridge beside data memory; irq feeds HWInt[0].

Parameters:
PRESCALE, 4, clock cycles per count decrement; used only when TIMER_PRESCALE_EN is defined; legal range 1..255

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
addr  input  2  word select (CPU address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=unused
we  input  1  write strobe, sampled on rising edge
wdata  input  32  write data
rdata  output  32  combinational read of the selected register; addr 3 reads 0
irq  output  1  interrupt request to CP0, registered

Behaviour:
- Registers:
  - CTRL[0] = EN.
  - CTRL[2:1] = MODE: 00 one-shot; 01 periodic; 10/11 behave as 00.
  - CTRL[3] = IM, interrupt mask, 1 = allow.
  - CTRL[31:4] read 0.
  - PRESET is 32-bit read/write.
  - COUNT is read-only; writes to it are ignored.
- Reset (async): CTRL=0, PRESET=0, COUNT=0, state=IDLE, pending=0, irq=0.
- A write takes effect on the edge where we=1.
- Any write to CTRL clears pending (acknowledge).
- If pending would be set on the same edge as a CTRL write, the set wins.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 -> LOAD, else stay.
  - LOAD: COUNT<=PRESET; -> CNT.
  - CNT, EN=0: -> IDLE; COUNT holds its value.
  - CNT, COUNT<=1: COUNT<=0; -> INT.
  - CNT, otherwise: COUNT<=COUNT-1.
  - INT: pending<=1.
    - Mode 00: EN bit cleared by hardware; -> IDLE; pending stays 1 until a CTRL write.
    - Mode 01: -> LOAD (auto-reload); pending<=0 on the next edge, so a 1-cycle pulse.
- irq = pending & IM, registered (same edge as pending).
- Latency:
  - CTRL write at edge E0 -> LOAD at E1 -> COUNT=PRESET at E2.
  - For PRESET=N>=1: COUNT reaches 0 and irq=1 at E(N+2).
  - PRESET=0 behaves as PRESET=1.
- Boundaries:
  - A PRESET write during CNT does not affect COUNT until the next LOAD.
  - EN cleared mid-count -> IDLE. Re-enabling reloads from PRESET; it does not resume.
  - A CTRL write with EN=1 during INT in mode 00: the software write of EN takes precedence over the hardware clear.
  - No wrap-around: COUNT never decrements below 0.
  - Reset asserted mid-count aborts immediately; irq drops asynchronously.

Optional Feature:
TIMER_PRESCALE_EN:
- Defined: CNT decrements only on a tick from a free-running prescaler that pulses once every PRESCALE cycles.
  - The prescaler is cleared in LOAD and IDLE.
  - INT entry is likewise gated by tick.
  - Latency for PRESET=N becomes 2 + N*PRESCALE edges.
- Undefined: tick is tied to 1; behaviour exactly as above; the PRESCALE parameter is ignored.

Decomposition:
- Shared package timer_pkg:
  - address constants ADDR_CTRL=0, ADDR_PRESET=1, ADDR_COUNT=2;
  - CTRL bit positions EN_BIT=0, MODE_LSB=1, IM_BIT=3;
  - mode encodings MODE_ONESHOT=2'b00, MODE_PERIODIC=2'b01;
  - FSM state encoding (2 bits).
- One sub-module, timer_prescaler: counter plus tick output with clear input; instantiated only under TIMER_PRESCALE_EN.

Test Plan:
1. Reset: assert reset mid-count (COUNT=5) asynchronously -> COUNT, CTRL, irq all 0 before the next clock edge; rdata at addr 0/1/2 = 0.
2. One-shot: write PRESET=3, then CTRL=0x9 (EN, IM, mode 00) at E0 -> COUNT reads 3, 2, 1, 0 at E2..E5; irq=1 from E5 and held; CTRL reads 0x8. A CTRL write of 0x8 -> irq=0 next edge.
3. Periodic: PRESET=2, CTRL=0xB -> irq is a one-cycle pulse every 4 edges (INT -> LOAD -> CNT x2), repeating ≥3 times; COUNT reloads to 2 each period.
4. Mask and pause:
   - CTRL=0x1 (IM=0), PRESET=2 -> COUNT reaches 0 with irq=0; a read of rdata shows COUNT=0.
   - Separately, clear EN at COUNT=7 -> COUNT stays 7; re-enable -> COUNT reloads to PRESET.
5. Register rules:
   - A write to addr 2 of 0x55 leaves COUNT unchanged.
   - A PRESET write of 10 during CNT leaves the running count unaffected; the next period uses 10.
   - addr 3 reads 0.
   - Same-edge set/ack conflict -> pending stays 1.
6. TIMER_PRESCALE_EN, PRESCALE=4, PRESET=2 -> irq asserts at edge E10; COUNT changes only every 4th edge.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: register map, CTRL bit layout, mode encodings and FSM states for timer_device.
package timer_pkg;
    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_PRESET   = 2'd1;
    localparam logic [1:0] ADDR_COUNT    = 2'd2;
    localparam int         EN_BIT        = 0;
    localparam int         MODE_LSB      = 1;
    localparam int         IM_BIT        = 3;
    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} state_t;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: free-running divider, tick pulses once every PRESCALE cycles; clr restarts the period.
module timer_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    logic [7:0] cnt;
    assign tick = cnt == 8'(PRESCALE - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else if (clr || tick) cnt <= '0;
        else cnt <= cnt + 8'd1;
    end
endmodule

// File: rtl/timer_device.sv
// timer_device: memory-mapped down-counting timer with CTRL/PRESET/COUNT registers and a registered irq.
// Define TIMER_PRESCALE_EN to slow the count to one decrement every PRESCALE cycles.
module timer_device
    import timer_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    state_t      state, state_n;
    logic        en, en_n, im, im_n, pending, pending_n, tick;
    logic [1:0]  mode;
    logic [31:0] preset, count, count_n;
    logic        wr_ctrl, periodic, fire, last;

    if (PRESCALE < 1 || PRESCALE > 255) begin : g_bad_prescale
        $error("timer_device: PRESCALE must be 1..255");
    end

`ifdef TIMER_PRESCALE_EN
    timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (state == ST_IDLE || state == ST_LOAD),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign wr_ctrl  = we && addr == ADDR_CTRL;
    assign periodic = mode == MODE_PERIODIC;
    assign last     = count <= 32'd1;
    assign fire     = state == ST_CNT && en && tick && last;

    always_comb begin
        state_n = state;
        count_n = count;
        case (state)
            ST_IDLE: state_n = en ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
                count_n = preset;
                state_n = ST_CNT;
            end
            ST_CNT: begin
                state_n = !en ? ST_IDLE : fire ? ST_INT : ST_CNT;
                count_n = !en || !tick ? count : last ? 32'd0 : count - 32'd1;
            end
            default: state_n = periodic ? ST_LOAD : ST_IDLE;
        endcase
    end

    // software EN write beats the one-shot hardware clear; a new expiry beats the CTRL-write ack
    assign en_n      = wr_ctrl ? wdata[EN_BIT] : (state == ST_INT && !periodic) ? 1'b0 : en;
    assign im_n      = wr_ctrl ? wdata[IM_BIT] : im;
    assign pending_n = fire || (pending && !wr_ctrl && !(state == ST_INT && periodic));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            count   <= '0;
            preset  <= '0;
            en      <= 1'b0;
            im      <= 1'b0;
            mode    <= MODE_ONESHOT;
            pending <= 1'b0;
            irq     <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            en      <= en_n;
            im      <= im_n;
            pending <= pending_n;
            irq     <= pending_n && im_n;
            if (wr_ctrl) mode <= wdata[MODE_LSB +: 2];
            if (we && addr == ADDR_PRESET) preset <= wdata;
        end
    end

    always_comb
        rdata = addr == ADDR_CTRL   ? {28'd0, im, mode, en} :
                addr == ADDR_PRESET ? preset :
                addr == ADDR_COUNT  ? count : 32'd0;
endmodule

// File: tb/tb_timer_device.sv
// tb_timer_device: random + directed stimulus against a behavioural timer model, checked every cycle.
module tb_timer_device;
    localparam int PRESCALE = 4;
`ifdef TIMER_PRESCALE_EN
    localparam int P = PRESCALE;
`else
    localparam int P = 1;
`endif
    logic        clk = 0, reset = 0, we = 0, irq;
    logic [1:0]  addr = 0;
    logic [31:0] wdata = 0, rdata;
    int          errors = 0, checks = 0, pulses;

    timer_device #(.PRESCALE(PRESCALE)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we),
        .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // model: phase 0 stopped, 1 reloading, 2 counting, 3 expired
    logic        m_en, m_im, m_pend, m_irq;
    logic [1:0]  m_mode;
    logic [31:0] m_preset, m_count;
    int          m_ph, m_pc;

    always @(posedge clk or posedge reset) begin : model
        logic t, wc, per, fire, n_en, n_pend;
        int n_ph;
        logic [31:0] n_cnt;
        if (reset) begin
            m_en <= 0; m_im <= 0; m_pend <= 0; m_irq <= 0; m_mode <= 0;
            m_preset <= 0; m_count <= 0; m_ph <= 0; m_pc <= 0;
        end else begin
            t = (m_pc % P) == P - 1;
            wc = we && addr == 2'd0;
            per = m_mode == 2'b01;
            fire = m_ph == 2 && m_en && t && m_count <= 1;
            n_ph = m_ph; n_cnt = m_count; n_en = m_en; n_pend = m_pend;
            if (m_ph == 0 && m_en) n_ph = 1;
            if (m_ph == 1) begin n_cnt = m_preset; n_ph = 2; end
            if (m_ph == 2) begin
                if (!m_en) n_ph = 0;
                else if (t) begin
                    n_cnt = m_count > 1 ? m_count - 1 : 0;
                    if (m_count <= 1) n_ph = 3;
                end
            end
            if (m_ph == 3) begin
                n_ph = per ? 1 : 0;
                if (per) n_pend = 0; else n_en = 0;
            end
            if (wc) begin
                n_en = wdata[0]; n_pend = 0;
                m_mode <= wdata[2:1]; m_im <= wdata[3];
            end
            if (fire) n_pend = 1;
            if (we && addr == 2'd1) m_preset <= wdata;
            m_pc <= m_ph < 2 ? 0 : m_pc + 1;
            m_ph <= n_ph; m_count <= n_cnt; m_en <= n_en; m_pend <= n_pend;
            m_irq <= n_pend && (wc ? wdata[3] : m_im);
        end
    end

    function automatic logic [31:0] m_rd(input logic [1:0] a);
        return a == 0 ? {28'd0, m_im, m_mode, m_en} : a == 1 ? m_preset : a == 2 ? m_count : 32'd0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (!reset) begin
            chk("model_rdata", rdata, m_rd(addr));
            chk("model_irq", 32'(irq), 32'(m_irq));
        end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; we = 1; wdata = d;
        cyc(1);
        we = 0;
    endtask

    task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] e);
        addr = a;
        #1;
        chk(nm, rdata, e);
    endtask

    initial begin
        #1 reset = 1;
        #2;
        rd("rst_ctrl", 0, 0); rd("rst_preset", 1, 0); rd("rst_count", 2, 0);
        chk("rst_irq", 32'(irq), 0);
        cyc(1);
        reset = 0;

        // one-shot, then acknowledge
        wr(1, 3); wr(0, 9);
        for (int k = 1; k <= 2 + 3 * P; k++) begin
            cyc(1);
            if (k >= 2) rd("os_count", 2, 32'(3 - (k - 2) / P));
            if (k == 1 + 3 * P) chk("os_irq_early", 32'(irq), 0);
        end
        chk("os_irq", 32'(irq), 1);
        cyc(2);
        chk("os_irq_held", 32'(irq), 1);
        rd("os_ctrl", 0, 32'h8);
        wr(0, 8);
        chk("os_ack", 32'(irq), 0);
        cyc(3);

        // asynchronous reset mid-count
        wr(1, 10); wr(0, 9);
        cyc(2 + 5 * P);
        rd("mid_count5", 2, 5);
        reset = 1;
        rd("arst_count", 2, 0); rd("arst_ctrl", 0, 0); rd("arst_preset", 1, 0);
        chk("arst_irq", 32'(irq), 0);
        cyc(1);
        reset = 0;

        // periodic
        wr(1, 2); wr(0, 32'hB);
        addr = 2;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            if (irq) pulses++;
            if (k >= 2 && (k - 2) % (2 + 2 * P) == 0) rd("per_reload", 2, 2);
        end
        chk("per_pulses", 32'(pulses), 32'(20 / (2 + 2 * P)));
        wr(0, 0);
        cyc(4);

        // masked expiry
        wr(1, 2); wr(0, 1);
        cyc(2 + 2 * P);
        rd("mask_count", 2, 0);
        chk("mask_irq", 32'(irq), 0);
        cyc(3);

        // pause and re-enable
        wr(1, 20); wr(0, 1);
        cyc(1 + 13 * P);
        wr(0, 0);
        cyc(3);
        rd("pause_hold", 2, 7);
        wr(0, 1);
        cyc(1);
        rd("pause_load_pending", 2, 7);
        cyc(1);
        rd("pause_reload", 2, 20);
        wr(0, 0);
        cyc(3);

        // register rules
        wr(1, 5); wr(0, 1);
        cyc(2);
        wr(2, 32'h55);
        rd("count_ro", 2, 32'(5 - 1 / P));
        wr(1, 10);
        rd("preset_mid", 2, 32'(5 - 2 / P));
        rd("preset_rb", 1, 10);
        cyc(2 + 5 * P - 2);
        wr(0, 1);
        cyc(2);
        rd("preset_next", 2, 10);
        wr(0, 0);
        cyc(3);
        rd("addr3", 3, 0);

        // same-edge set and ack, then async irq drop
        wr(1, 2); wr(0, 9);
        cyc(1 + 2 * P);
        wr(0, 8);
        chk("conflict_irq", 32'(irq), 1);
        rd("conflict_ctrl", 0, 32'h8);
        cyc(2);
        chk("conflict_held", 32'(irq), 1);
        reset = 1;
        #1;
        chk("arst_irq_drop", 32'(irq), 0);
        cyc(1);
        reset = 0;

        // software EN wins over hardware clear in expiry state
        wr(1, 2); wr(0, 9);
        cyc(2 + 2 * P);
        wr(0, 9);
        rd("en_wins", 0, 32'h9);
        chk("en_wins_irq", 32'(irq), 0);
        wr(0, 0);
        cyc(4);

        // random traffic
        repeat (3000) begin
            int r;
            logic [1:0] a;
            logic [31:0] d;
            r = int'($urandom_range(0, 199));
            a = 2'($urandom_range(0, 3));
            if (r < 50) begin
                d = a == 0 ? 32'($urandom_range(0, 15)) : a == 1 ? 32'($urandom_range(0, 6)) : $urandom;
                wr(a, d);
            end else if (r == 199) begin
                reset = 1;
                #1;
                chk("rnd_arst_irq", 32'(irq), 0);
                cyc(1);
                reset = 0;
            end else begin
                addr = a;
                cyc(1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
